// File: rtl/adc_sample_reader.sv
// ---------------------------------------------------------------------------
// adc_sample_reader
//
// Acquisition controller for the panel-voltage path. For each START it issues
// 2^AVG_LOG2 start-of-conversion pulses to the XADC wrapper, one at a time.
// After each pulse it waits for end-of-conversion and captures the 12-bit
// result into a boxcar accumulator. When the last sample arrives it publishes
// the truncated mean together with a one-cycle valid strobe. If a conversion
// does not complete within TIMEOUT wait cycles, the acquisition is abandoned
// and a sticky error flag is raised.
//
// Parameters:
//   AVG_LOG2  log2 of samples per average (0..4); N = 2**AVG_LOG2
//   TIMEOUT   WAIT cycles allowed per conversion before abort (>= 2)
//
// Ports:
//   CLK       system clock (pll_clk domain)
//   RST       synchronous, active-high reset
//   START     acquisition request, only honoured while idle
//   ADC_EOC   end-of-conversion pulse from the XADC
//   ADC_DATA  conversion result, valid while ADC_EOC = 1
//   ADC_SOC   registered start-of-conversion pulse, one cycle wide
//   V_AVG     last completed averaged voltage
//   V_VALID   one-cycle strobe, coincident with a V_AVG update
//   BUSY      high in every state except IDLE
//   ERR       sticky conversion-timeout flag
// ---------------------------------------------------------------------------
module adc_sample_reader #(
    parameter int AVG_LOG2 = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        ADC_EOC,
    input  logic [11:0] ADC_DATA,
    output logic        ADC_SOC,
    output logic [11:0] V_AVG,
    output logic        V_VALID,
    output logic        BUSY,
    output logic        ERR
);

    // Samples per average and register widths. The accumulator is wide enough
    // for N full-scale samples, so the sum never overflows.
    localparam int N     = 1 << AVG_LOG2;
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [TMR_W-1:0]  tmr_reg;
    logic              adc_soc_reg;
    logic [11:0]       v_avg_reg;
    logic              v_valid_reg;
    logic              busy_reg;
    logic              err_reg;

    // Running sum including the sample currently on ADC_DATA.
    logic [ACC_W-1:0]  acc_sum;
    assign acc_sum = acc_reg + ACC_W'(ADC_DATA);

    // The TIMEOUT-th WAIT cycle is the one where the timer still shows
    // TIMEOUT-1. The timer starts at zero in the first WAIT cycle.
    logic              wait_expired;
    assign wait_expired = (tmr_reg == LAST_TMR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            tmr_reg     <= '0;
            adc_soc_reg <= 1'b0;
            v_avg_reg   <= '0;
            v_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            // Strobes are high for exactly one cycle unless re-armed below.
            adc_soc_reg <= 1'b0;
            v_valid_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // Conversion results arriving here are ignored.
                    if (START) begin
                        acc_reg     <= '0;
                        cnt_reg     <= '0;
                        tmr_reg     <= '0;
                        err_reg     <= 1'b0;
                        adc_soc_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SOC;
                    end
                end

                ST_SOC: begin
                    // An EOC seen here belongs to an earlier request and is
                    // deliberately dropped.
                    tmr_reg   <= '0;
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    tmr_reg <= tmr_reg + 1'b1;
                    // A sample arriving in the final allowed cycle still
                    // counts, so EOC takes priority over the timeout.
                    if (ADC_EOC) begin
                        if (cnt_reg == LAST_CNT) begin
                            // The top 12 bits of the full sum are the
                            // truncated mean (sum >> AVG_LOG2).
                            v_avg_reg   <= acc_sum[ACC_W-1 -: 12];
                            v_valid_reg <= 1'b1;
                            state_reg   <= ST_DONE;
                        end else begin
                            acc_reg     <= acc_sum;
                            cnt_reg     <= cnt_reg + 1'b1;
                            adc_soc_reg <= 1'b1;
                            state_reg   <= ST_SOC;
                        end
                    end else if (wait_expired) begin
                        // Abandon the acquisition. The partial sum is
                        // discarded and the published average is kept.
                        err_reg   <= 1'b1;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ADC_SOC = adc_soc_reg;
    assign V_AVG   = v_avg_reg;
    assign V_VALID = v_valid_reg;
    assign BUSY    = busy_reg;
    assign ERR     = err_reg;

endmodule

// File: tb/tb_adc_sample_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_reader
//
// Directed sequence with randomized sample values and conversion latencies.
// The XADC is emulated by answering each SOC with an EOC after a chosen delay.
// The expected average is the arithmetic mean (integer division) of the
// samples that were actually returned for the acquisition.
// ---------------------------------------------------------------------------
module tb_adc_sample_reader;

    localparam int AVG_LOG2 = 3;
    localparam int N        = 1 << AVG_LOG2;
    localparam int TIMEOUT  = 255;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        ADC_EOC;
    logic [11:0] ADC_DATA;
    logic        ADC_SOC;
    logic [11:0] V_AVG;
    logic        V_VALID;
    logic        BUSY;
    logic        ERR;

    adc_sample_reader #(
        .AVG_LOG2(AVG_LOG2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .ADC_EOC (ADC_EOC),
        .ADC_DATA(ADC_DATA),
        .ADC_SOC (ADC_SOC),
        .V_AVG   (V_AVG),
        .V_VALID (V_VALID),
        .BUSY    (BUSY),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acq_no = 0;

    // Pulse bookkeeping, sampled on the falling edge.
    int   soc_pulses     = 0;
    int   valid_pulses   = 0;
    int   soc_back2back  = 0;
    int   valid_back2back = 0;
    logic prev_soc       = 1'b0;
    logic prev_valid     = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (ADC_SOC === 1'b1) soc_pulses <= soc_pulses + 1;
        if (V_VALID === 1'b1) valid_pulses <= valid_pulses + 1;
        if (prev_soc && ADC_SOC === 1'b1) soc_back2back <= soc_back2back + 1;
        if (prev_valid && V_VALID === 1'b1) valid_back2back <= valid_back2back + 1;
        prev_soc   <= (ADC_SOC === 1'b1);
        prev_valid <= (V_VALID === 1'b1);
    end

    // Reference state: samples for the current acquisition and the value
    // V_AVG is expected to hold.
    logic [11:0] smp [N];
    logic [11:0] exp_avg = 12'h000;

    function automatic logic [11:0] model_mean();
        int sum;
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'(smp[i]);
        return 12'(sum / N);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One acquisition. fail_at: index of the conversion that never answers
    // (-1 = none). rst_at: index whose SOC cycle gets a reset (-1 = none).
    // stale: inject EOCs in SOC and IDLE cycles. hold: leave START high.
    task automatic run_acq(input int dly_max, input bit stale, input int fail_at,
                           input int rst_at, input bit hold, input bit chk_timing);
        int c0, soc0, val0, t, dly;
        logic [11:0] exp;
        soc0 = soc_pulses;
        val0 = valid_pulses;
        START = 1'b1;
        tick();                         // edge 0 samples START
        c0 = cyc;
        ADC_EOC = 1'b0;
        if (!hold) START = 1'b0;
        check("soc_after_start", 32'(ADC_SOC), 32'd1);
        check("busy_after_start", 32'(BUSY), 32'd1);
        check("err_cleared_on_start", 32'(ERR), 32'd0);
        for (int i = 0; i < N; i++) begin
            t = 0;
            while (ADC_SOC !== 1'b1 && t < 8) begin
                tick();
                t++;
            end
            check("soc_seen", 32'(ADC_SOC), 32'd1);
            if (i == rst_at) begin
                RST = 1'b1;
                ADC_EOC = 1'b0;
                tick();
                RST = 1'b0;
                check("rst_busy", 32'(BUSY), 32'd0);
                check("rst_soc", 32'(ADC_SOC), 32'd0);
                check("rst_vavg", 32'(V_AVG), 32'd0);
                exp_avg = 12'h000;
                repeat (3) tick();
                check("rst_no_valid", 32'(valid_pulses - val0), 32'd0);
                check("rst_stays_idle", 32'(BUSY), 32'd0);
                $display("acq %0d: reset after %0d samples, busy=%0b", acq_no, i, BUSY);
                acq_no++;
                return;
            end
            if (stale) begin
                ADC_EOC  = 1'b1;
                ADC_DATA = 12'($urandom);
            end
            tick();                     // first WAIT cycle
            ADC_EOC = 1'b0;
            if (i == fail_at) begin
                repeat (TIMEOUT - 1) tick();
                check("last_wait_busy", 32'(BUSY), 32'd1);
                check("last_wait_no_err", 32'(ERR), 32'd0);
                tick();
                check("timeout_err", 32'(ERR), 32'd1);
                check("timeout_busy", 32'(BUSY), 32'd0);
                check("timeout_vavg_kept", 32'(V_AVG), 32'(exp_avg));
                check("timeout_no_valid", 32'(valid_pulses - val0), 32'd0);
                check("timeout_soc_count", 32'(soc_pulses - soc0), 32'(fail_at + 1));
                $display("acq %0d: timeout at sample %0d, err=%0b v_avg=0x%03h", acq_no, i, ERR, V_AVG);
                acq_no++;
                return;
            end
            dly = (dly_max > 0) ? int'($urandom_range(0, dly_max)) : 0;
            repeat (dly) tick();
            ADC_EOC  = 1'b1;
            ADC_DATA = smp[i];
            tick();
            ADC_EOC  = 1'b0;
            ADC_DATA = 12'($urandom);
        end
        exp = model_mean();
        check("done_valid", 32'(V_VALID), 32'd1);
        check("done_vavg", 32'(V_AVG), 32'(exp));
        check("done_busy", 32'(BUSY), 32'd1);
        if (chk_timing) check("valid_cycle", 32'(cyc - c0 + 1), 32'(2 * N + 1));
        exp_avg = exp;
        $display("acq %0d: v_avg=0x%03h expected=0x%03h", acq_no, V_AVG, exp);
        acq_no++;
        tick();                         // first IDLE cycle
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_valid_low", 32'(V_VALID), 32'd0);
        check("soc_count", 32'(soc_pulses - soc0), 32'(N));
        check("valid_count", 32'(valid_pulses - val0), 32'd1);
        if (stale) begin
            ADC_EOC  = 1'b1;
            ADC_DATA = 12'($urandom);
        end
    endtask

    task automatic idle_cycles(input int n);
        START   = 1'b0;
        ADC_EOC = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs.
        RST = 1'b1;
        START = 1'b0;
        ADC_EOC = 1'b0;
        ADC_DATA = 12'h000;
        repeat (3) begin
            START    = 1'($urandom);
            ADC_EOC  = 1'($urandom);
            ADC_DATA = 12'($urandom);
            tick();
            check("reset_soc", 32'(ADC_SOC), 32'd0);
            check("reset_busy", 32'(BUSY), 32'd0);
            check("reset_valid", 32'(V_VALID), 32'd0);
            check("reset_err", 32'(ERR), 32'd0);
            check("reset_vavg", 32'(V_AVG), 32'd0);
        end
        RST = 1'b0;
        idle_cycles(2);
        check("reset_no_soc_pulse", 32'(soc_pulses), 32'd0);

        // Constant input, immediate EOC, timing check.
        for (int i = 0; i < N; i++) smp[i] = 12'hABC;
        run_acq(0, 1'b0, -1, -1, 1'b0, 1'b1);
        idle_cycles(1);

        // Alternating 0x000 / 0xFFF.
        for (int i = 0; i < N; i++) smp[i] = (i % 2 == 0) ? 12'h000 : 12'hFFF;
        run_acq(0, 1'b0, -1, -1, 1'b0, 1'b1);
        idle_cycles(1);

        // Full scale.
        for (int i = 0; i < N; i++) smp[i] = 12'hFFF;
        run_acq(2, 1'b0, -1, -1, 1'b0, 1'b0);
        idle_cycles(2);

        // Timeout after the third SOC.
        for (int i = 0; i < N; i++) smp[i] = 12'($urandom);
        run_acq(2, 1'b0, 2, -1, 1'b0, 1'b0);
        idle_cycles(5);
        check("err_sticky", 32'(ERR), 32'd1);
        check("err_idle_busy", 32'(BUSY), 32'd0);

        // Next START clears ERR and completes normally.
        for (int i = 0; i < N; i++) smp[i] = 12'($urandom);
        run_acq(3, 1'b0, -1, -1, 1'b0, 1'b0);
        idle_cycles(1);

        // START held high, stale EOCs in SOC and IDLE cycles, back-to-back.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) smp[i] = 12'($urandom);
            run_acq(3, 1'b1, -1, -1, 1'b1, 1'b0);
        end
        idle_cycles(2);

        // Mid-operation reset after the fifth sample, then fresh acquisition.
        for (int i = 0; i < N; i++) smp[i] = 12'($urandom);
        run_acq(1, 1'b0, -1, 5, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) smp[i] = 12'h100;
        run_acq(0, 1'b0, -1, -1, 1'b0, 1'b1);
        idle_cycles(1);

        // Random acquisitions with random latencies.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) smp[i] = 12'($urandom);
            run_acq(3, k[0], -1, -1, 1'b0, 1'b0);
            idle_cycles(1 + k);
        end

        idle_cycles(2);
        check("soc_never_back2back", 32'(soc_back2back), 32'd0);
        check("valid_never_back2back", 32'(valid_back2back), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
